// File: rtl/lc3b_types.sv
// Shared LC-3b control types: opcodes, datapath mux selects, the per-stage
// control word carried down the pipe, and the indirect-sequencer states.
package lc3b_types;

   typedef enum logic [3:0] {
      OP_BR   = 4'b0000,
      OP_ADD  = 4'b0001,
      OP_LDB  = 4'b0010,
      OP_STB  = 4'b0011,
      OP_JSR  = 4'b0100,
      OP_AND  = 4'b0101,
      OP_LDR  = 4'b0110,
      OP_STR  = 4'b0111,
      OP_RTI  = 4'b1000,
      OP_NOT  = 4'b1001,
      OP_LDI  = 4'b1010,
      OP_STI  = 4'b1011,
      OP_JMP  = 4'b1100,
      OP_SHF  = 4'b1101,
      OP_LEA  = 4'b1110,
      OP_TRAP = 4'b1111
   } lc3b_opcode;

   typedef enum logic [1:0] {ALU_ADD, ALU_AND, ALU_NOT, ALU_PASS} lc3b_aluop;
   typedef enum logic [1:0] {ALUMUX_SR2, ALUMUX_IMM5, ALUMUX_ADJ6} lc3b_alumux;
   typedef enum logic [1:0] {MEMMUX_RESULT, MEMMUX_RDATA, MEMMUX_PCADDER} lc3b_memmux;
   typedef enum logic {DESTMUX_DEST, DESTMUX_R7} lc3b_destmux;
   typedef enum logic [1:0] {ADDRMUX_ALU, ADDRMUX_MDR, ADDRMUX_VECTOR} lc3b_addrmux;
   typedef enum logic {PCMUX_ADDER, PCMUX_BASER} lc3b_pcmux;

   // Which half of a two-step LDI/STI sequence is being decoded
   typedef enum logic {UOP_1, UOP_2} lc3b_uop;

   // Indirect sequencer state
   typedef enum logic {ST_IDLE, ST_IND} pipe_state_t;

   typedef struct packed {
      lc3b_opcode  opcode;
      lc3b_aluop   aluop;
      lc3b_alumux  alumux;
      lc3b_memmux  memmux;
      lc3b_destmux destmux;
      lc3b_addrmux addrmux;
      lc3b_pcmux   pcmux;
      logic        load_cc;
      logic        load_regfile;
      logic        mem_read;
      logic        mem_write;
      logic [1:0]  mem_wmask;
      logic        mem_byte;
      logic        indirect;
      logic        branch;
      logic        jump;
      logic        link;
   } lc3b_control_word;

   localparam lc3b_control_word CTRL_DEFAULT = '{
      opcode:       OP_BR,
      aluop:        ALU_PASS,
      alumux:       ALUMUX_SR2,
      memmux:       MEMMUX_RESULT,
      destmux:      DESTMUX_DEST,
      addrmux:      ADDRMUX_ALU,
      pcmux:        PCMUX_ADDER,
      load_cc:      1'b0,
      load_regfile: 1'b0,
      mem_read:     1'b0,
      mem_write:    1'b0,
      mem_wmask:    2'b11,
      mem_byte:     1'b0,
      indirect:     1'b0,
      branch:       1'b0,
      jump:         1'b0,
      link:         1'b0
   };

   function automatic logic is_indirect(input lc3b_opcode op);
      return (op == OP_LDI) || (op == OP_STI);
   endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational LC-3b decode of one instruction (or one LDI/STI half) into a control word.
module control_decode
   import lc3b_types::*;
(
   input  lc3b_opcode       opcode,
   input  logic             imm,
   input  logic             jsr,
   input  lc3b_uop          uop,
   output lc3b_control_word ctrl
);

   // Start from defaults, then set only the fields each opcode needs
   always_comb begin
      ctrl        = CTRL_DEFAULT;
      ctrl.opcode = opcode;
      case (opcode)
         OP_ADD, OP_AND: begin
            ctrl.aluop        = (opcode == OP_ADD) ? ALU_ADD : ALU_AND;
            ctrl.alumux       = imm ? ALUMUX_IMM5 : ALUMUX_SR2;
            ctrl.load_cc      = 1'b1;
            ctrl.load_regfile = 1'b1;
         end
         OP_NOT: begin
            ctrl.aluop        = ALU_NOT;
            ctrl.load_cc      = 1'b1;
            ctrl.load_regfile = 1'b1;
         end
         OP_LDR, OP_LDB: begin
            ctrl.aluop        = ALU_ADD;
            ctrl.alumux       = ALUMUX_ADJ6;
            ctrl.memmux       = MEMMUX_RDATA;
            ctrl.mem_read     = 1'b1;
            ctrl.load_cc      = 1'b1;
            ctrl.load_regfile = 1'b1;
            ctrl.mem_byte     = (opcode == OP_LDB);
         end
         OP_STR, OP_STB: begin
            ctrl.aluop     = ALU_ADD;
            ctrl.alumux    = ALUMUX_ADJ6;
            ctrl.mem_write = 1'b1;
            ctrl.mem_byte  = (opcode == OP_STB);
         end
         OP_LEA: begin
            ctrl.memmux       = MEMMUX_PCADDER;
            ctrl.load_cc      = 1'b1;
            ctrl.load_regfile = 1'b1;
         end
         OP_BR: ctrl.branch = 1'b1;
         OP_JMP: begin
            ctrl.jump  = 1'b1;
            ctrl.pcmux = PCMUX_BASER;
         end
         OP_JSR: begin
            ctrl.jump         = 1'b1;
            ctrl.link         = 1'b1;
            ctrl.destmux      = DESTMUX_R7;
            ctrl.load_regfile = 1'b1;
            ctrl.pcmux        = jsr ? PCMUX_ADDER : PCMUX_BASER;
         end
         OP_TRAP: begin
            ctrl.link         = 1'b1;
            ctrl.destmux      = DESTMUX_R7;
            ctrl.load_regfile = 1'b1;
            ctrl.mem_read     = 1'b1;
            ctrl.addrmux      = ADDRMUX_VECTOR;
         end
         OP_LDI, OP_STI: begin
            if (uop == UOP_1) begin
               // First half: fetch the pointer
               ctrl.aluop    = ALU_ADD;
               ctrl.alumux   = ALUMUX_ADJ6;
               ctrl.mem_read = 1'b1;
               ctrl.memmux   = MEMMUX_RDATA;
               ctrl.indirect = 1'b1;
            end else if (opcode == OP_LDI) begin
               ctrl.mem_read     = 1'b1;
               ctrl.addrmux      = ADDRMUX_MDR;
               ctrl.memmux       = MEMMUX_RDATA;
               ctrl.load_cc      = 1'b1;
               ctrl.load_regfile = 1'b1;
            end else begin
               ctrl.mem_write = 1'b1;
               ctrl.addrmux   = ADDRMUX_MDR;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_pipe.sv
// Control-word pipeline: decode slot feeds STAGES registered stages, with
// stall/flush handling and a two-state sequencer splitting LDI/STI in two uops.
module control_pipe
   import lc3b_types::*;
#(
   parameter int unsigned STAGES       = 3,
   parameter int unsigned FLUSH_STAGES = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [3:0]          opcode,
   input  logic                imm,
   input  logic                jsr,
   input  logic                valid_in,
   input  logic                stall,
   input  logic                flush,
   output logic                ready_out,
   output lc3b_control_word    ctrl_out [STAGES],
   output logic [STAGES-1:0]   valid_out
);

   localparam logic [STAGES-1:0] FLUSH_MASK = (STAGES'(1) << FLUSH_STAGES) - STAGES'(1);

   pipe_state_t       state, state_next;
   lc3b_uop           uop;
   lc3b_opcode        op;
   lc3b_control_word  dec_word;
   lc3b_control_word  stage_q [STAGES];
   logic [STAGES-1:0] valid_q, valid_d;

   assign op        = lc3b_opcode'(opcode);
   assign valid_out = valid_q;

   control_decode u_decode (
      .opcode (op),
      .imm    (imm),
      .jsr    (jsr),
      .uop    (uop),
      .ctrl   (dec_word)
   );

   // Sequencer state register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Sequencer next state, uop select and fetch handshake
   always_comb begin
      state_next = state;
      uop        = UOP_1;
      ready_out  = 1'b1;
      case (state)
         ST_IDLE: begin
            if (valid_in && is_indirect(op)) ready_out = 1'b0;
            if (!stall && valid_in && is_indirect(op)) state_next = ST_IND;
         end
         ST_IND: begin
            uop = UOP_2;
            if (!stall) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
      if (stall) ready_out = 1'b0;
      if (flush) state_next = ST_IDLE;
   end

   // Valid bits: shift when not stalled, then kill the youngest stages on flush
   always_comb begin
      valid_d = stall ? valid_q : {valid_q[STAGES-2:0], valid_in};
      if (flush) valid_d = valid_d & ~FLUSH_MASK;
   end

   // Stage registers: advance one stage per cycle unless stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int k = 0; k < STAGES; k++) stage_q[k] <= CTRL_DEFAULT;
      end else begin
         valid_q <= valid_d;
         if (!stall) begin
            stage_q[0] <= valid_in ? dec_word : CTRL_DEFAULT;
            for (int k = 1; k < STAGES; k++) stage_q[k] <= stage_q[k-1];
         end
      end
   end

   // Suppress architectural side effects of invalid stages
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         ctrl_out[k] = stage_q[k];
         if (!valid_q[k]) begin
            ctrl_out[k].load_cc      = 1'b0;
            ctrl_out[k].load_regfile = 1'b0;
            ctrl_out[k].mem_read     = 1'b0;
            ctrl_out[k].mem_write    = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_control_pipe.sv
// Self-checking bench for control_pipe: directed scenarios then random traffic,
// all compared against a field-level behavioural model of the pipe.
module tb_control_pipe;
   import lc3b_types::*;

   localparam int unsigned NS = 3;

   logic clk = 1'b0;
   logic rst, imm, jsr, valid_in, stall, flush, ready_out;
   logic [3:0] opcode;
   lc3b_control_word ctrl_out [NS];
   logic [NS-1:0] valid_out;

   int checks = 0;
   int errors = 0;

   // Model state: ungated stage words, valids, and "second half of LDI/STI pending"
   lc3b_control_word m_ctrl [NS];
   logic [NS-1:0] m_valid;
   bit m_pend;

   control_pipe #(.STAGES(NS), .FLUSH_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .opcode    (opcode),
      .imm       (imm),
      .jsr       (jsr),
      .valid_in  (valid_in),
      .stall     (stall),
      .flush     (flush),
      .ready_out (ready_out),
      .ctrl_out  (ctrl_out),
      .valid_out (valid_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic lc3b_control_word ref_default();
      lc3b_control_word w;
      w.opcode = OP_BR;        w.aluop = ALU_PASS;      w.alumux = ALUMUX_SR2;
      w.memmux = MEMMUX_RESULT; w.destmux = DESTMUX_DEST; w.addrmux = ADDRMUX_ALU;
      w.pcmux = PCMUX_ADDER;   w.load_cc = 1'b0;        w.load_regfile = 1'b0;
      w.mem_read = 1'b0;       w.mem_write = 1'b0;      w.mem_wmask = 2'b11;
      w.mem_byte = 1'b0;       w.indirect = 1'b0;       w.branch = 1'b0;
      w.jump = 1'b0;           w.link = 1'b0;
      return w;
   endfunction

   // Field-by-field statement of which opcodes assert which control
   function automatic lc3b_control_word ref_decode(input lc3b_opcode op, input logic i,
                                                   input logic j, input bit second);
      lc3b_control_word w = ref_default();
      logic mem_op, ind1, ldi2, sti2;
      mem_op = op inside {OP_LDR, OP_LDB, OP_STR, OP_STB};
      ind1   = (op inside {OP_LDI, OP_STI}) && !second;
      ldi2   = (op == OP_LDI) && second;
      sti2   = (op == OP_STI) && second;
      w.opcode  = op;
      w.aluop   = (op == OP_ADD) ? ALU_ADD : (op == OP_AND) ? ALU_AND :
                  (op == OP_NOT) ? ALU_NOT : (mem_op || ind1) ? ALU_ADD : ALU_PASS;
      w.alumux  = ((op inside {OP_ADD, OP_AND}) && i) ? ALUMUX_IMM5 :
                  (mem_op || ind1) ? ALUMUX_ADJ6 : ALUMUX_SR2;
      w.memmux  = ((op inside {OP_LDR, OP_LDB}) || ind1 || ldi2) ? MEMMUX_RDATA :
                  (op == OP_LEA) ? MEMMUX_PCADDER : MEMMUX_RESULT;
      w.destmux = (op inside {OP_JSR, OP_TRAP}) ? DESTMUX_R7 : DESTMUX_DEST;
      w.addrmux = (ldi2 || sti2) ? ADDRMUX_MDR : (op == OP_TRAP) ? ADDRMUX_VECTOR : ADDRMUX_ALU;
      w.pcmux   = ((op == OP_JMP) || (op == OP_JSR && !j)) ? PCMUX_BASER : PCMUX_ADDER;
      w.load_cc      = (op inside {OP_ADD, OP_AND, OP_NOT, OP_LDR, OP_LDB, OP_LEA}) || ldi2;
      w.load_regfile = w.load_cc || (op inside {OP_JSR, OP_TRAP});
      w.mem_read  = (op inside {OP_LDR, OP_LDB, OP_TRAP}) || ind1 || ldi2;
      w.mem_write = (op inside {OP_STR, OP_STB}) || sti2;
      w.mem_byte  = op inside {OP_LDB, OP_STB};
      w.indirect  = ind1;
      w.branch    = (op == OP_BR);
      w.jump      = op inside {OP_JMP, OP_JSR};
      w.link      = op inside {OP_JSR, OP_TRAP};
      return w;
   endfunction

   function automatic lc3b_control_word gated(input lc3b_control_word w, input logic v);
      lc3b_control_word g = w;
      if (!v) begin
         g.load_cc = 1'b0; g.load_regfile = 1'b0; g.mem_read = 1'b0; g.mem_write = 1'b0;
      end
      return g;
   endfunction

   task automatic model_update();
      lc3b_opcode op = lc3b_opcode'(opcode);
      if (rst) begin
         for (int k = 0; k < NS; k++) m_ctrl[k] = ref_default();
         m_valid = '0;
         m_pend  = 1'b0;
      end else begin
         if (!stall) begin
            for (int k = NS - 1; k > 0; k--) begin
               m_ctrl[k]  = m_ctrl[k-1];
               m_valid[k] = m_valid[k-1];
            end
            m_ctrl[0]  = valid_in ? ref_decode(op, imm, jsr, m_pend) : ref_default();
            m_valid[0] = valid_in;
            m_pend = m_pend ? 1'b0 : (valid_in && (op inside {OP_LDI, OP_STI}));
         end
         if (flush) begin
            m_valid[0] = 1'b0;
            m_valid[1] = 1'b0;
            m_pend     = 1'b0;
         end
      end
   endtask

   // One clock: drive inputs, check handshake, clock, check every stage
   task automatic step(input logic r, input logic v, input logic s, input logic f,
                       input lc3b_opcode op, input logic i, input logic j);
      logic exp_ready;
      @(negedge clk);
      rst = r; valid_in = v; stall = s; flush = f; opcode = op; imm = i; jsr = j;
      #1;
      exp_ready = !(s || (!m_pend && v && (op inside {OP_LDI, OP_STI})));
      check("ready", 64'(ready_out), 64'(exp_ready));
      @(posedge clk);
      model_update();
      #1;
      check("valid", 64'(valid_out), 64'(m_valid));
      for (int k = 0; k < NS; k++)
         check($sformatf("ctrl%0d", k), 64'(ctrl_out[k]), 64'(gated(m_ctrl[k], m_valid[k])));
   endtask

   initial begin
      rst = 1'b1; valid_in = 1'b0; stall = 1'b0; flush = 1'b0;
      opcode = 4'h0; imm = 1'b0; jsr = 1'b0;
      for (int k = 0; k < NS; k++) m_ctrl[k] = ref_default();
      m_valid = '0; m_pend = 1'b0;

      // Reset
      step(1, 0, 0, 0, OP_BR, 0, 0);
      step(1, 0, 0, 0, OP_BR, 0, 0);
      check("rst_valid", 64'(valid_out), 64'(3'b000));
      step(0, 0, 0, 0, OP_BR, 0, 0);

      // ADD immediate walks down the pipe
      step(0, 1, 0, 0, OP_ADD, 1, 0);
      check("add_v1", 64'(valid_out), 64'(3'b001));
      check("add_mux", 64'(ctrl_out[0].alumux), 64'(ALUMUX_IMM5));
      check("add_op", 64'(ctrl_out[0].aluop), 64'(ALU_ADD));
      check("add_ldreg", 64'(ctrl_out[0].load_regfile), 64'(1'b1));
      step(0, 0, 0, 0, OP_ADD, 1, 0);
      check("add_v2", 64'(valid_out), 64'(3'b010));
      step(0, 0, 0, 0, OP_ADD, 1, 0);
      check("add_v3", 64'(valid_out), 64'(3'b100));
      check("add_mux2", 64'(ctrl_out[2].alumux), 64'(ALUMUX_IMM5));

      // LDI splits into two uops
      step(0, 1, 0, 0, OP_LDI, 0, 0);
      check("ldi_u1_rd", 64'(ctrl_out[0].mem_read), 64'(1'b1));
      check("ldi_u1_ld", 64'(ctrl_out[0].load_regfile), 64'(1'b0));
      check("ldi_ready_ind", 64'(ready_out), 64'(1'b1));
      step(0, 1, 0, 0, OP_LDI, 0, 0);
      check("ldi_u2_ld", 64'(ctrl_out[0].load_regfile), 64'(1'b1));
      check("ldi_u2_cc", 64'(ctrl_out[0].load_cc), 64'(1'b1));
      step(0, 0, 0, 0, OP_BR, 0, 0);

      // STR held three cycles by stall, then advances
      step(0, 1, 0, 0, OP_STR, 0, 0);
      for (int n = 0; n < 3; n++) step(0, 1, 1, 0, OP_STR, 0, 0);
      check("str_hold", 64'(ctrl_out[0].mem_write), 64'(1'b1));
      step(0, 0, 0, 0, OP_BR, 0, 0);
      check("str_adv", 64'(ctrl_out[1].mem_write), 64'(1'b1));

      // Flush under stall kills the two youngest stages only
      for (int n = 0; n < 3; n++) step(0, 1, 0, 0, OP_AND, 0, 0);
      step(0, 1, 1, 1, OP_NOT, 0, 0);
      check("flush_v", 64'(valid_out), 64'(3'b100));
      check("flush_s2", 64'(ctrl_out[2].aluop), 64'(ALU_AND));

      // STI first half, then flush while in the indirect state
      step(0, 1, 0, 0, OP_STI, 0, 0);
      step(0, 1, 0, 1, OP_STI, 0, 0);
      for (int k = 0; k < NS; k++)
         check($sformatf("sti_nowr%0d", k), 64'(ctrl_out[k].mem_write), 64'(1'b0));
      step(0, 0, 0, 0, OP_BR, 0, 0);

      // Reset overrides stall with a full pipe
      for (int n = 0; n < 3; n++) step(0, 1, 0, 0, OP_LDR, 0, 0);
      step(1, 1, 1, 0, OP_LDR, 0, 0);
      check("rst_stall_v", 64'(valid_out), 64'(3'b000));

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 75,
              $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 10,
              lc3b_opcode'(4'($urandom_range(0, 15))),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
